// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
package bin_to_bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_OVF_NIBBLE = 4'hF;

    // Largest value representable in the given number of BCD digits (digits <= 8 fits 32 bits).
    function automatic logic [31:0] pow10_minus1(input int digits);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational add-3 correction for one BCD digit
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero mask output enabled by BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int W      = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done,
    output logic                  overflow
`ifdef BCD_LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BW    = 4 * DIGITS;
    localparam int CW    = (W > BW) ? W : BW;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CW-1:0] LIMIT = CW'(pow10_minus1(DIGITS));

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       bin_q;
    logic [BW-1:0]      work_q;
    logic [BW-1:0]      work_adj;
    logic [BW-1:0]      work_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pending;
    logic               accept;
    logic               last;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (work_q[4*g +: 4]),
                .digit_out (work_adj[4*g +: 4])
            );
        end
    endgenerate

    // Bits leaving the top of the work register are dropped; overflow covers that case.
    assign work_next = {work_adj[BW-2:0], bin_q[W-1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q       <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            ovf_pending <= 1'b0;
        end else if (accept) begin
            bin_q       <= value;
            work_q      <= '0;
            cnt_q       <= CNT_W'(W);
            ovf_pending <= (CW'(value) > LIMIT);
        end else if (state == SHIFT) begin
            bin_q       <= bin_q << 1;
            work_q      <= work_next;
            cnt_q       <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                bcd      <= ovf_pending ? {DIGITS{BCD_OVF_NIBBLE}} : work_next;
                overflow <= ovf_pending;
            end
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              all_zero;

    // Scan from the most significant digit down; digit 0 always stays lit.
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (work_next[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
        if (ovf_pending) begin
            blank_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank <= '0;
        end else if (last) begin
            blank <= blank_next;
        end
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed and randomized self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    localparam int W      = 20;
    localparam int DIGITS = 6;
    localparam int TMO    = 100;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W-1:0]        value = '0;
    logic [4*DIGITS-1:0] bcd;
    logic                done;
    logic                overflow;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .value    (value),
        .bcd      (bcd),
        .done     (done),
        .overflow (overflow)
`ifdef BCD_LEADING_ZERO_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_bcd(input logic [31:0] v);
        logic [23:0] r;
        logic [31:0] t;
        r = '0;
        if (v > 32'd999999) begin
            r = 24'hFFFFFF;
        end else begin
            t = v;
            for (int i = 0; i < 6; i++) begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    // Caller must be #1 after an edge with in_ready high; returns at the sample where done is seen.
    task automatic run_conv(input logic [W-1:0] v, output int n, output logic [23:0] b,
                            output logic o, output logic stable);
        logic [23:0] prev;
        prev     = bcd;
        stable   = 1'b1;
        in_valid = 1'b1;
        value    = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < TMO) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (bcd !== prev) stable = 1'b0;
        end
        if (n >= TMO) begin
            $display("FAIL timeout value=%0d no done within %0d cycles", v, TMO);
            bad++;
        end
        b = bcd;
        o = overflow;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || done !== 1'b0 || bcd !== 24'h0 || overflow !== 1'b0) begin
            $display("FAIL reset_state ready=%b done=%b bcd=%h ovf=%b want 1 0 000000 0",
                     in_ready, done, bcd, overflow);
            bad++;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        total++;
        if (blank !== 6'b000000) begin
            $display("FAIL reset_blank got=%b want=000000", blank);
            bad++;
        end
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int n; logic [23:0] b; logic o; logic s;
        run_conv(20'd0, n, b, o, s);
        total++;
        if (n !== W) begin
            $display("FAIL zero_latency got=%0d want=%0d", n, W);
            bad++;
        end
        total++;
        if (b !== 24'h000000 || o !== 1'b0) begin
            $display("FAIL zero_value bcd=%h ovf=%b want 000000 0", b, o);
            bad++;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        total++;
        if (blank !== 6'b111110) begin
            $display("FAIL zero_blank got=%b want=111110", blank);
            bad++;
        end
`endif
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            $display("FAIL done_width done still %b one cycle later", done);
            bad++;
        end
    endtask

    task automatic test_values();
        int n; logic [23:0] b; logic o; logic s;
        run_conv(20'd123456, n, b, o, s);
        total++;
        if (b !== 24'h123456 || o !== 1'b0) begin
            $display("FAIL val_123456 bcd=%h ovf=%b want 123456 0", b, o);
            bad++;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        total++;
        if (blank !== 6'b000000) begin
            $display("FAIL blank_123456 got=%b want=000000", blank);
            bad++;
        end
`endif
        @(posedge clk); #1;
        run_conv(20'd999999, n, b, o, s);
        total++;
        if (b !== 24'h999999 || o !== 1'b0) begin
            $display("FAIL val_999999 bcd=%h ovf=%b want 999999 0", b, o);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int n; logic [23:0] b; logic o; logic s;
        run_conv(20'd1000000, n, b, o, s);
        total++;
        if (b !== 24'hFFFFFF || o !== 1'b1) begin
            $display("FAIL ovf_1000000 bcd=%h ovf=%b want ffffff 1", b, o);
            bad++;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        total++;
        if (blank !== 6'b000000) begin
            $display("FAIL ovf_blank got=%b want=000000", blank);
            bad++;
        end
`endif
        @(posedge clk); #1;
        run_conv(20'd5, n, b, o, s);
        total++;
        if (b !== 24'h000005 || o !== 1'b0) begin
            $display("FAIL ovf_clear bcd=%h ovf=%b want 000005 0", b, o);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n; logic [23:0] b; logic o; logic s;
        logic ready_low;
        logic extra;
        run_conv(20'd7, n, b, o, s);
        total++;
        if (b !== 24'h000007 || in_ready !== 1'b1) begin
            $display("FAIL b2b_first bcd=%h ready=%b want 000007 1", b, in_ready);
            bad++;
        end
        in_valid  = 1'b1;
        value     = 20'd42;
        ready_low = 1'b1;
        n = 0;
        while (n < TMO) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (in_ready !== 1'b0) ready_low = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (n !== W + 1) begin
            $display("FAIL b2b_spacing got=%0d want=%0d", n, W + 1);
            bad++;
        end
        total++;
        if (bcd !== 24'h000042 || ready_low !== 1'b1) begin
            $display("FAIL b2b_second bcd=%h ready_low=%b want 000042 1", bcd, ready_low);
            bad++;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        total++;
        if (blank !== 6'b111100) begin
            $display("FAIL b2b_blank got=%b want=111100", blank);
            bad++;
        end
`endif
        extra = 1'b0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || in_ready !== 1'b1) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            $display("FAIL b2b_extra extra_activity=%b want 0", extra);
            bad++;
        end
    endtask

    task automatic test_reset_abort();
        int n; logic [23:0] b; logic o; logic s;
        logic seen_done;
        in_valid = 1'b1;
        value    = 20'd999999;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (bcd !== 24'h0 || in_ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL abort_state bcd=%h ready=%b done=%b want 000000 1 0", bcd, in_ready, done);
            bad++;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            $display("FAIL abort_no_done saw done=%b want 0", seen_done);
            bad++;
        end
        run_conv(20'd65535, n, b, o, s);
        total++;
        if (b !== 24'h065535 || o !== 1'b0) begin
            $display("FAIL abort_after bcd=%h ovf=%b want 065535 0", b, o);
            bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n; logic [23:0] b; logic o; logic s;
        logic [W-1:0] v;
        logic [23:0] exp_b;
        for (int k = 0; k < 1500; k++) begin
            v = W'($urandom_range(0, (1 << W) - 1));
            exp_b = ref_bcd(32'(v));
            run_conv(v, n, b, o, s);
            total++;
            if (b !== exp_b || o !== (32'(v) > 32'd999999) || s !== 1'b1 || n !== W) begin
                $display("FAIL random value=%0d bcd=%h ovf=%b stable=%b lat=%0d want %h %b 1 %0d",
                         v, b, o, s, n, exp_b, (32'(v) > 32'd999999), W);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
